// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with fixed XLen+1 cycle latency
module muldiv_unit #(
  parameter  int XLen      = 32,
  parameter  int NReg      = 32,
  localparam int NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [XLen-1:0]      a_i,
  input  logic [XLen-1:0]      b_i,
  input  logic [NRegWidth-1:0] rd_i,
  input  logic                 kill_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [XLen-1:0]      result_o,
  output logic [NRegWidth-1:0] rd_o
);

  localparam int CntW = $clog2(XLen + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q;
  logic                   neg_a_q, neg_b_q, b_zero_q;
  logic [XLen-1:0]        opd_q;
  logic [2*XLen-1:0]      prod_q;
  logic [CntW-1:0]        cnt_q;
  logic [XLen-1:0]        result_q;
  logic [NRegWidth-1:0]   rd_q;

  logic                   accept, iterating, last_iter;
  logic                   a_signed, b_signed;
  logic [XLen-1:0]        mag_a, mag_b;
  logic [XLen:0]          mul_sum;
  logic [2*XLen-1:0]      mul_next, mul_fix;
  logic [XLen:0]          div_shift;
  logic                   div_ge;
  logic [XLen-1:0]        div_rem;
  logic [2*XLen-1:0]      div_next;
  logic [XLen-1:0]        quot, rem, quot_fix, rem_fix;
  logic [XLen-1:0]        mul_res, div_res, final_res;

  assign accept    = (state_q == IDLE) && start_i && !kill_i;
  assign iterating = (state_q == MUL) || (state_q == DIV);
  assign last_iter = iterating && (cnt_q == CntW'(XLen - 1));

  // Operand signedness from funct3; magnitudes feed the unsigned core
  always_comb begin
    a_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    mag_a    = (a_signed && a_i[XLen-1]) ? -a_i : a_i;
    mag_b    = (b_signed && b_i[XLen-1]) ? -b_i : b_i;
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step on the shared product register
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLen-1:XLen]} + (prod_q[0] ? {1'b0, opd_q} : '0);
    mul_next  = {mul_sum, prod_q[XLen-1:1]};
    div_shift = prod_q[2*XLen-1:XLen-1];
    div_ge    = div_shift >= {1'b0, opd_q};
    div_rem   = div_ge ? (div_shift[XLen-1:0] - opd_q) : div_shift[XLen-1:0];
    div_next  = {div_rem, prod_q[XLen-2:0], div_ge};
  end

  // Sign correction and result selection applied to the final step's value
  always_comb begin
    mul_fix   = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
    mul_res   = (op_q == 2'b00) ? mul_fix[XLen-1:0] : mul_fix[2*XLen-1:XLen];
    quot      = div_next[XLen-1:0];
    rem       = div_next[2*XLen-1:XLen];
    quot_fix  = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quot : quot);
    rem_fix   = neg_a_q ? -rem : rem;
    div_res   = op_q[1] ? rem_fix : quot_fix;
    final_res = (state_q == DIV) ? div_res : mul_res;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; kill from any state returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_i[2] ? DIV : MUL;
      MUL,
      DIV:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // Operand capture on acceptance, iteration, and result capture on the last step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      opd_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      op_q     <= op_i[1:0];
      neg_a_q  <= a_signed && a_i[XLen-1];
      neg_b_q  <= b_signed && b_i[XLen-1];
      b_zero_q <= (b_i == '0);
      opd_q    <= op_i[2] ? mag_b : mag_a;
      prod_q   <= {{XLen{1'b0}}, (op_i[2] ? mag_a : mag_b)};
      cnt_q    <= '0;
      rd_q     <= rd_i;
    end else if (iterating && !kill_i) begin
      prod_q <= (state_q == DIV) ? div_next : mul_next;
      cnt_q  <= cnt_q + CntW'(1);
      if (last_iter) result_q <= final_res;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE) && !kill_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule
